// File: rtl/tx_arbiter_pkg.sv
// rtl/tx_arbiter_pkg.sv - shared states, defaults and requester indices for the AVR transmit arbiter
package tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_ID      = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_SETTLE  = 3'd4
  } tx_state_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ID_BASE   = 8'h10;

  localparam int REQ_DEBUG = 0;
  localparam int REQ_TELEM = 1;
  localparam int REQ_FLAGS = 2;
  localparam int REQ_SPARE = 3;

  // Hold-off after each strobe; covers the rise latency of avr_interface tx_busy.
  localparam int SETTLE_CYCLES = 2;

  function automatic logic [7:0] id_byte(input logic [7:0] base, input logic [7:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// rtl/tx_arbiter_rr_pick.sv - combinational N-way round-robin picker, search starts at pointer+1
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic          valid
);

  always_comb begin
    logic [PW-1:0] idx;
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(pointer) + k) % N);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin packet arbiter framing SYNC, ID, payload onto the AVR transmit path
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int         N         = 4,
  parameter int         MAX_LEN   = 32,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter logic [7:0] ID_BASE   = DEF_ID_BASE
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   byte_ack,
  output logic [N-1:0]   grant,
  output logic [7:0]     tx_data,
  output logic           new_tx_data,
  input  logic           tx_busy,
  output logic           busy,
  output logic           err_trunc,
  output logic           err_abort
);

  localparam int         PW          = $clog2(N);
  localparam int         CW          = $clog2(MAX_LEN + 1);
  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  tx_state_t     state;
  tx_state_t     ret_state;
  logic [1:0]    settle_cnt;
  logic [PW-1:0] pointer;
  logic [PW-1:0] gidx;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          hit_max;

  logic [N-1:0]  pick_grant;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;

  logic          cur_req;
  logic          cur_last;
  logic [7:0]    cur_data;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req     (req),
    .pointer (pointer),
    .grant   (pick_grant),
    .valid   (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_grant[i]) pick_idx = PW'(i);
    end
  end

  assign cur_req    = req[gidx];
  assign cur_last   = req_last[gidx];
  assign cur_data   = req_data[{gidx, 3'b000} +: 8];
  assign count_next = count + 1'b1;
  assign hit_max    = (count_next == CW'(MAX_LEN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ret_state   <= ST_IDLE;
      settle_cnt  <= '0;
      pointer     <= PW'(N - 1);
      gidx        <= '0;
      count       <= '0;
      byte_ack    <= '0;
      grant       <= '0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
      busy        <= 1'b0;
      err_trunc   <= 1'b0;
      err_abort   <= 1'b0;
    end else begin
      new_tx_data <= 1'b0;
      byte_ack    <= '0;
      err_trunc   <= 1'b0;
      err_abort   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant <= pick_grant;
            gidx  <= pick_idx;
            busy  <= 1'b1;
            state <= ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (!tx_busy) begin
            tx_data     <= SYNC_BYTE;
            new_tx_data <= 1'b1;
            ret_state   <= ST_ID;
            settle_cnt  <= SETTLE_LAST;
            state       <= ST_SETTLE;
          end
        end

        ST_ID: begin
          if (!tx_busy) begin
            tx_data     <= id_byte(ID_BASE, 8'(gidx));
            new_tx_data <= 1'b1;
            ret_state   <= ST_PAYLOAD;
            settle_cnt  <= SETTLE_LAST;
            state       <= ST_SETTLE;
          end
        end

        ST_PAYLOAD: begin
          if (!tx_busy) begin
            if (cur_req) begin
              tx_data        <= cur_data;
              new_tx_data    <= 1'b1;
              byte_ack[gidx] <= 1'b1;
              count          <= count_next;
              settle_cnt     <= SETTLE_LAST;
              state          <= ST_SETTLE;
              if (cur_last || hit_max) begin
                ret_state <= ST_IDLE;
                pointer   <= gidx;
                err_trunc <= !cur_last && hit_max;
              end else begin
                ret_state <= ST_PAYLOAD;
              end
            end else begin
              // Owner vanished mid-packet: drop it without sending anything further.
              err_abort <= 1'b1;
              grant     <= '0;
              busy      <= 1'b0;
              count     <= '0;
              pointer   <= gidx;
              state     <= ST_IDLE;
            end
          end
        end

        ST_SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
          end else begin
            state <= ret_state;
            if (ret_state == ST_IDLE) begin
              grant <= '0;
              busy  <= 1'b0;
              count <= '0;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
